apb_slave_regs: RTL and testbench

APB responder that sits on one `psel` line of the AHB-to-APB bridge and terminates its APB transfers. It tracks the two-phase APB protocol (setup, then access) and holds a bank of 32-bit registers, including a read-only ID word and a transfer-counter word. It flags any protocol violation from the initiator with a sticky error. There is no `pready`: every transfer completes in exactly one setup cycle plus one access cycle, matching the bridge timing.

---
 rtl/apb_resp_pkg.sv | 22 ++
 rtl/apb_phase_fsm.sv | 62 ++++++
 rtl/apb_slave_regs.sv | 115 +++++++++++
 tb/tb_apb_slave_regs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_resp_pkg.sv
// Shared types and constants for the APB register responder.
// Covers the phase encoding, the default ID word and the fixed register slots.
package apb_resp_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } phase_t;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA9B0_0001;

    // The two highest register indices are reserved for the counter and ID words.
    function automatic int counter_slot(input int num_regs);
        return num_regs - 2;
    endfunction

    function automatic int id_slot(input int num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/apb_phase_fsm.sv
// APB setup/access phase tracker.
// Latches the setup address/direction, flags protocol violations and signals commits.
module apb_phase_fsm
    import apb_resp_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic             psel,
    input  logic             penable,
    input  logic             pwrite,
    input  logic [31:0]      paddr,
    output logic             commit,
    output logic             setup_evt,
    output logic             violation,
    output logic             commit_write,
    output logic [IDX_W-1:0] commit_idx
);

    phase_t      state_reg;
    logic [31:0] addr_reg;
    logic        write_reg;
    logic        access_ok;

    assign setup_evt    = psel & ~penable;
    assign access_ok    = psel & penable & (paddr == addr_reg) & (pwrite == write_reg);
    assign commit_write = write_reg;
    assign commit_idx   = addr_reg[IDX_W+1:2];

    // Commit must act in the access cycle itself so a following setup sees the new data.
    always_comb begin
        commit    = 1'b0;
        violation = 1'b0;
        case (state_reg)
            PH_IDLE:   violation = psel & penable;
            PH_SETUP: begin
                commit    = access_ok;
                violation = ~access_ok;
            end
            PH_ACCESS: violation = psel & penable;
            default:   violation = 1'b0;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg <= PH_IDLE;
            addr_reg  <= '0;
            write_reg <= 1'b0;
        end else if (setup_evt) begin
            state_reg <= PH_SETUP;
            addr_reg  <= paddr;
            write_reg <= pwrite;
        end else if (commit) begin
            state_reg <= PH_ACCESS;
        end else begin
            state_reg <= PH_IDLE;
        end
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB responder with a general register bank, transfer counters, an ID word
// and a sticky protocol-error flag. Every transfer is exactly setup + access.
module apb_slave_regs
    import apb_resp_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic        err_clr,
    output logic [31:0] prdata,
    output logic        perr
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] CNT_SLOT = IDX_W'(counter_slot(NUM_REGS));
    localparam logic [IDX_W-1:0] ID_SLOT  = IDX_W'(id_slot(NUM_REGS));

    logic             commit;
    logic             setup_evt;
    logic             violation;
    logic             commit_write;
    logic [IDX_W-1:0] commit_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_value;
    logic [31:0]      gp_q [NUM_REGS];
    logic [15:0]      wr_cnt_reg;
    logic [15:0]      rd_cnt_reg;
    logic [31:0]      prdata_reg;
    logic             perr_reg;

    apb_phase_fsm #(
        .IDX_W(IDX_W)
    ) u_phase_fsm (
        .hclk        (hclk),
        .hreset      (hreset),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .commit      (commit),
        .setup_evt   (setup_evt),
        .violation   (violation),
        .commit_write(commit_write),
        .commit_idx  (commit_idx)
    );

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi < NUM_REGS - 2) begin : g_rw
            logic [31:0] q_reg;
            always_ff @(posedge hclk) begin
                if (hreset) begin
                    q_reg <= '0;
                end else if (commit && commit_write && commit_idx == IDX_W'(gi)) begin
                    q_reg <= pwdata;
                end
            end
            assign gp_q[gi] = q_reg;
        end else begin : g_fixed
            assign gp_q[gi] = '0;
        end
    end

    assign rd_idx = paddr[IDX_W+1:2];

    always_comb begin
        rd_value = gp_q[rd_idx];
        if (rd_idx == CNT_SLOT) begin
            rd_value = {wr_cnt_reg, rd_cnt_reg};
        end else if (rd_idx == ID_SLOT) begin
            rd_value = ID_VALUE;
        end
    end

    // A write to the counter slot is itself a counted access; the clear takes priority.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
        end else if (commit) begin
            if (commit_write && commit_idx == CNT_SLOT) begin
                wr_cnt_reg <= '0;
                rd_cnt_reg <= '0;
            end else if (commit_write) begin
                if (wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end else begin
                if (rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            prdata_reg <= '0;
            perr_reg   <= 1'b0;
        end else begin
            if (setup_evt) prdata_reg <= rd_value;
            if (violation) begin
                perr_reg <= 1'b1;
            end else if (err_clr) begin
                perr_reg <= 1'b0;
            end
        end
    end

    assign prdata = prdata_reg;
    assign perr   = perr_reg;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: directed scenarios then random traffic, all checked
// against a transaction-level model of the register map, counters and error flag.
module tb_apb_slave_regs;

    localparam int NUM_REGS = 16;
    localparam logic [31:0] ID_WORD = 32'hA9B0_0001;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        err_clr;
    logic [31:0] prdata;
    logic        perr;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [NUM_REGS];
    int          m_wr;
    int          m_rd;
    logic        m_perr;
    logic [31:0] m_prdata;

    always #5 hclk = ~hclk;

    apb_slave_regs #(
        .NUM_REGS(NUM_REGS),
        .ID_VALUE(ID_WORD)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .err_clr(err_clr),
        .prdata (prdata),
        .perr   (perr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx == NUM_REGS - 1) return ID_WORD;
        if (idx == NUM_REGS - 2) return {16'(m_wr), 16'(m_rd)};
        return m_regs[idx];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_wr = 0;
        m_rd = 0;
        m_perr = 1'b0;
        m_prdata = '0;
    endtask

    task automatic m_commit(input logic wr, input int idx, input logic [31:0] data);
        if (wr) begin
            if (idx == NUM_REGS - 2) begin
                m_wr = 0;
                m_rd = 0;
            end else begin
                if (idx < NUM_REGS - 2) m_regs[idx] = data;
                if (m_wr < 65535) m_wr++;
            end
        end else if (m_rd < 65535) begin
            m_rd++;
        end
    endtask

    function automatic logic [31:0] rand_addr(input int idx);
        logic [31:0] r;
        r = $urandom();
        r[5:2] = 4'(idx);
        return r;
    endfunction

    // One clock edge with the currently driven inputs, then compare both outputs.
    task automatic step(input bit viol, input string tag);
        if (viol) m_perr = 1'b1;
        else if (err_clr) m_perr = 1'b0;
        @(posedge hclk);
        #1;
        chk({tag, " perr"}, {31'b0, perr}, {31'b0, m_perr});
        chk({tag, " prdata"}, prdata, m_prdata);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        m_prdata = m_read(idx_of(a));
        step(1'b0, "setup");
        penable = 1'b1;
        m_commit(wr, idx_of(a), d);
        step(1'b0, "access");
        $display("txn %s addr=%h wdata=%h prdata=%h", wr ? "WR" : "RD", a, d, prdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            psel = 1'b0; penable = 1'b0; paddr = $urandom(); pwrite = 1'($urandom());
            step(1'b0, "idle");
        end
    endtask

    task automatic idle_viol(input logic clr);
        psel = 1'b1; penable = 1'b1; pwrite = 1'($urandom()); paddr = $urandom();
        pwdata = $urandom(); err_clr = clr;
        step(1'b1, "idle_viol");
        err_clr = 1'b0;
        $display("txn IDLE_VIOL clr=%0b perr=%0b", clr, perr);
    endtask

    task automatic clear_err();
        psel = 1'b0; penable = 1'b0; err_clr = 1'b1;
        step(1'b0, "err_clr");
        err_clr = 1'b0;
        $display("txn ERR_CLR perr=%0b", perr);
    endtask

    // Setup followed by a malformed access of the given kind.
    task automatic bad_access(input int kind, input logic wr, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        m_prdata = m_read(idx_of(a));
        step(1'b0, "bad setup");
        case (kind)
            0: begin penable = 1'b1; paddr = b; step(1'b1, "bad addr"); end
            1: begin penable = 1'b1; pwrite = ~wr; step(1'b1, "bad dir"); end
            2: begin psel = 1'b0; penable = 1'b1; step(1'b1, "bad desel"); end
            default: begin
                penable = 1'b0; paddr = b; pwrite = ~wr;
                m_prdata = m_read(idx_of(b));
                step(1'b1, "resetup");
                penable = 1'b1;
                m_commit(~wr, idx_of(b), d);
                step(1'b0, "resetup access");
            end
        endcase
        $display("txn BAD kind=%0d addr=%h alt=%h perr=%0b", kind, a, b, perr);
    endtask

    initial begin
        hreset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; err_clr = 1'b0;
        m_reset();
        repeat (2) @(posedge hclk);
        #1;
        chk("reset prdata", prdata, 32'h0);
        chk("reset perr", {31'b0, perr}, 32'h0);
        hreset = 1'b0;
        idle(1);

        xfer(1'b1, 32'h0000_000C, 32'hDEADBEEF);
        xfer(1'b0, 32'h0000_000C, 32'h0);
        chk("rd 0x0C", prdata, 32'hDEADBEEF);
        xfer(1'b0, 32'h0000_0038, 32'h0);
        chk("cnt 1/1", prdata, 32'h0001_0001);

        xfer(1'b0, 32'h0000_003C, 32'h0);
        chk("id rd", prdata, ID_WORD);
        xfer(1'b1, 32'h0000_003C, 32'h0);
        xfer(1'b0, 32'h0000_003C, 32'h0);
        chk("id after wr", prdata, ID_WORD);

        xfer(1'b1, 32'h0000_0000, 32'd1);
        xfer(1'b1, 32'h0000_0004, 32'd2);
        xfer(1'b1, 32'h0000_0008, 32'd3);
        xfer(1'b0, 32'h0000_0000, 32'h0);
        chk("b2b r0", prdata, 32'd1);
        xfer(1'b0, 32'h0000_0004, 32'h0);
        chk("b2b r1", prdata, 32'd2);
        xfer(1'b0, 32'h0000_0008, 32'h0);
        chk("b2b r2", prdata, 32'd3);
        chk("b2b perr", {31'b0, perr}, 32'h0);
        idle(1);

        idle_viol(1'b0);
        chk("idle viol perr", {31'b0, perr}, 32'h1);
        clear_err();
        chk("err_clr perr", {31'b0, perr}, 32'h0);
        idle_viol(1'b1);
        chk("viol+clr perr", {31'b0, perr}, 32'h1);
        clear_err();

        bad_access(0, 1'b1, 32'h0000_0004, 32'h0000_0008, 32'h5555_AAAA);
        chk("bad perr", {31'b0, perr}, 32'h1);
        clear_err();
        xfer(1'b0, 32'h0000_0004, 32'h0);
        chk("bad r1", prdata, 32'd2);
        xfer(1'b0, 32'h0000_0008, 32'h0);
        chk("bad r2", prdata, 32'd3);
        xfer(1'b0, 32'h0000_0038, 32'h0);
        chk("bad cnt", prdata, 32'h0005_0009);

        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_0010; pwdata = 32'h1234_5678;
        hreset = 1'b1;
        @(posedge hclk);
        #1;
        m_reset();
        chk("mid reset prdata", prdata, 32'h0);
        chk("mid reset perr", {31'b0, perr}, 32'h0);
        hreset = 1'b0;
        penable = 1'b1;
        step(1'b1, "post reset access");
        chk("post reset perr", {31'b0, perr}, 32'h1);
        clear_err();
        xfer(1'b0, 32'h0000_0010, 32'h0);
        chk("aborted wr", prdata, 32'h0);
        xfer(1'b1, 32'h0000_0038, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h0000_0038, 32'h0);
        chk("cnt clr", prdata, 32'h0);

        for (int n = 0; n < 300; n++) begin
            int op;
            int ia;
            int ib;
            op = int'($urandom_range(0, 9));
            ia = int'($urandom_range(0, NUM_REGS - 1));
            if (op <= 5) begin
                xfer(1'($urandom()), rand_addr(ia), $urandom());
                if ($urandom_range(0, 1) == 1) idle(1);
            end else if (op == 6) begin
                idle_viol(1'($urandom()));
            end else if (op == 7) begin
                logic [31:0] a;
                logic [31:0] b;
                a = rand_addr(ia);
                b = a ^ (32'h1 << $urandom_range(0, 31));
                ib = int'($urandom_range(0, NUM_REGS - 1));
                if ($urandom_range(0, 3) == 3) b = rand_addr(ib);
                if (b == a) b = a ^ 32'h4;
                bad_access(int'($urandom_range(0, 3)), 1'($urandom()), a, b, $urandom());
            end else if (op == 8) begin
                clear_err();
            end else begin
                idle(int'($urandom_range(1, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
